// File: rtl/conv_pkg.sv
// Shared definitions for the conv_accum accumulation stage: datapath widths,
// FSM state encoding and the saturating adder used when CONV_ACC_SAT_EN is set.
package conv_pkg;

    localparam int ACC_W = 32;
    localparam int Q_W   = 8;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

    // Unsigned add that pins to all-ones on carry out. Once the accumulator
    // reaches all-ones, any further addend keeps it there.
    function automatic logic [ACC_W-1:0] sat_add32(
        input logic [ACC_W-1:0] a,
        input logic [ACC_W-1:0] b
    );
        logic [ACC_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[ACC_W]) begin
            return {ACC_W{1'b1}};
        end else begin
            return s[ACC_W-1:0];
        end
    endfunction

endpackage

// File: rtl/conv_requant.sv
// Combinational requantizer: shifts a 32-bit accumulated sum right by SHIFT
// and clamps the result to the unsigned 8-bit range.
module conv_requant
    import conv_pkg::*;
#(
    parameter int SHIFT = 8
) (
    input  logic [ACC_W-1:0] sum,
    output logic [Q_W-1:0]   q
);

    logic [ACC_W-1:0] shifted_s;

    assign shifted_s = sum >> SHIFT;

    // Clamp: any set bit above the 8-bit range saturates to 255.
    always_comb begin
        q = '0;
        if (|shifted_s[ACC_W-1:Q_W]) begin
            q = {Q_W{1'b1}};
        end else begin
            q = shifted_s[Q_W-1:0];
        end
    end

endmodule

// File: rtl/conv_accum.sv
// conv_accum: sums a stream of 32-bit partial sums (one pixel per in_last-
// terminated burst) and holds the raw sum plus an 8-bit requantized value on a
// valid/ready output. Optional feature macro: CONV_ACC_SAT_EN (saturate the
// accumulator on carry instead of wrapping).
module conv_accum
    import conv_pkg::*;
#(
    parameter  int SHIFT     = 8,
    parameter  int MAX_TERMS = 64,
    localparam int CNT_W     = $clog2(MAX_TERMS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ACC_W-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [Q_W-1:0]   out_q,
    output logic [CNT_W-1:0] out_terms,
    output logic             ovf
);

    acc_state_t       state_r;
    acc_state_t       state_next_s;
    logic [ACC_W-1:0] acc_r;
    logic [CNT_W-1:0] cnt_r;

    logic             xfer_s;
    logic [ACC_W:0]   sum_wide_s;
    logic             carry_s;
    logic [ACC_W-1:0] acc_next_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             limit_s;
    logic             last_s;
    logic [Q_W-1:0]   q_s;

    // Ready depends only on the registered state: no path from out_ready/in_valid.
    assign in_ready   = (state_r == ACCUM);
    assign xfer_s     = in_valid && in_ready;

    assign sum_wide_s = {1'b0, acc_r} + {1'b0, in_data};
    assign carry_s    = sum_wide_s[ACC_W];

`ifdef CONV_ACC_SAT_EN
    assign acc_next_s = sat_add32(acc_r, in_data);
`else
    assign acc_next_s = sum_wide_s[ACC_W-1:0];
`endif

    assign cnt_inc_s  = cnt_r + CNT_W'(1'b1);
    // Reaching the term limit closes the pixel even without in_last.
    assign limit_s    = (cnt_inc_s == CNT_W'(MAX_TERMS));
    assign last_s     = in_last || limit_s;

    // Requantize the value being latched so out_q always matches out_data.
    conv_requant #(
        .SHIFT (SHIFT)
    ) u_requant (
        .sum (acc_next_s),
        .q   (q_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ACCUM;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state: close a pixel on its last beat, release on out_ready.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ACCUM: begin
                if (xfer_s && last_s) begin
                    state_next_s = HOLD;
                end else begin
                    state_next_s = ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next_s = ACCUM;
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: begin
                state_next_s = ACCUM;
            end
        endcase
    end

    // Accumulator, beat counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r     <= '0;
            cnt_r     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_q     <= '0;
            out_terms <= '0;
        end else if (xfer_s) begin
            if (last_s) begin
                out_data  <= acc_next_s;
                out_q     <= q_s;
                out_terms <= cnt_inc_s;
                out_valid <= 1'b1;
                acc_r     <= '0;
                cnt_r     <= '0;
            end else begin
                acc_r     <= acc_next_s;
                cnt_r     <= cnt_inc_s;
            end
        end else if ((state_r == HOLD) && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky overflow flag: carry out or term limit hit without in_last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (xfer_s && (carry_s || (limit_s && !in_last))) begin
            ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_conv_accum.sv
// Directed self-checking bench for conv_accum. DUT "a" uses default
// parameters; DUT "b" uses MAX_TERMS=4 for the term-limit case.
module tb_conv_accum;

    logic        clk;
    logic        rst_n;

    logic        in_valid, in_ready, in_last, out_valid, out_ready, ovf;
    logic [31:0] in_data, out_data;
    logic [7:0]  out_q;
    logic [6:0]  out_terms;

    logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_ovf;
    logic [31:0] b_in_data, b_out_data;
    logic [7:0]  b_out_q;
    logic [2:0]  b_out_terms;

    int compared   = 0;
    int mismatched = 0;

`ifdef CONV_ACC_SAT_EN
    localparam logic [31:0] OVF_DATA = 32'hFFFF_FFFF;
    localparam logic [31:0] OVF_Q    = 32'd255;
`else
    localparam logic [31:0] OVF_DATA = 32'h0000_0010;
    localparam logic [31:0] OVF_Q    = 32'd0;
`endif

    conv_accum u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_q     (out_q),
        .out_terms (out_terms),
        .ovf       (ovf)
    );

    conv_accum #(.SHIFT(8), .MAX_TERMS(4)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_last   (b_in_last),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_q     (b_out_q),
        .out_terms (b_out_terms),
        .ovf       (b_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = 32'd0; in_last = 1'b0; out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = 32'd0; b_in_last = 1'b0; b_out_ready = 1'b1;
        cyc(); cyc();

        // Reset state
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  out_data,       32'd0);
        chk("rst_out_q",     32'(out_q),     32'd0);
        chk("rst_out_terms", 32'(out_terms), 32'd0);
        chk("rst_ovf",       32'(ovf),       32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready",  32'(in_ready),  32'd1);

        // Pixel 100+200+300
        in_valid = 1'b1; in_data = 32'd100; in_last = 1'b0; cyc();
        in_data = 32'd200; cyc();
        chk("p1_mid_valid", 32'(out_valid), 32'd0);
        in_data = 32'd300; in_last = 1'b1; cyc();
        in_valid = 1'b0; in_last = 1'b0;
        chk("p1_valid",    32'(out_valid), 32'd1);
        chk("p1_data",     out_data,       32'd600);
        chk("p1_q",        32'(out_q),     32'd2);
        chk("p1_terms",    32'(out_terms), 32'd3);
        chk("p1_in_ready", 32'(in_ready),  32'd0);
        cyc();
        chk("p1_valid_drop", 32'(out_valid), 32'd0);
        chk("p1_ready_back", 32'(in_ready),  32'd1);

        // Single beat, clamped requant
        in_valid = 1'b1; in_data = 32'd70000; in_last = 1'b1; cyc();
        in_valid = 1'b0; in_last = 1'b0;
        chk("p2_valid", 32'(out_valid), 32'd1);
        chk("p2_data",  out_data,       32'd70000);
        chk("p2_q",     32'(out_q),     32'd255);
        chk("p2_terms", 32'(out_terms), 32'd1);
        cyc();
        chk("p2_valid_drop", 32'(out_valid), 32'd0);

        // Back-pressure: hold result with in_valid asserted
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'd5; in_last = 1'b1; cyc();
        chk("p3_valid", 32'(out_valid), 32'd1);
        chk("p3_data",  out_data,       32'd5);
        in_data = 32'd9;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("p3_hold_valid", 32'(out_valid), 32'd1);
            chk("p3_hold_data",  out_data,       32'd5);
            chk("p3_hold_terms", 32'(out_terms), 32'd1);
            chk("p3_hold_ready", 32'(in_ready),  32'd0);
        end
        out_ready = 1'b1; cyc();
        chk("p3_release_valid", 32'(out_valid), 32'd0);
        chk("p3_release_ready", 32'(in_ready),  32'd1);
        cyc();
        in_valid = 1'b0; in_last = 1'b0;
        chk("p4_valid", 32'(out_valid), 32'd1);
        chk("p4_data",  out_data,       32'd9);
        chk("p4_terms", 32'(out_terms), 32'd1);
        cyc();
        chk("p4_valid_drop", 32'(out_valid), 32'd0);
        chk("pre_ovf", 32'(ovf), 32'd0);

        // Carry out of the 32-bit add
        in_valid = 1'b1; in_data = 32'hFFFF_FFF0; in_last = 1'b0; cyc();
        in_data = 32'h0000_0020; in_last = 1'b1; cyc();
        in_valid = 1'b0; in_last = 1'b0;
        chk("ovf_flag",  32'(ovf),       32'd1);
        chk("ovf_valid", 32'(out_valid), 32'd1);
        chk("ovf_data",  out_data,       OVF_DATA);
        chk("ovf_q",     32'(out_q),     OVF_Q);
        chk("ovf_terms", 32'(out_terms), 32'd2);
        cyc();

        // Term limit on MAX_TERMS=4 instance: six beats of 1, no last
        b_in_valid = 1'b1; b_in_data = 32'd1; b_in_last = 1'b0;
        cyc(); cyc(); cyc();
        chk("lim_pre_valid", 32'(b_out_valid), 32'd0);
        chk("lim_pre_ovf",   32'(b_ovf),       32'd0);
        cyc();
        chk("lim_valid", 32'(b_out_valid), 32'd1);
        chk("lim_terms", 32'(b_out_terms), 32'd4);
        chk("lim_data",  b_out_data,       32'd4);
        chk("lim_q",     32'(b_out_q),     32'd0);
        chk("lim_ovf",   32'(b_ovf),       32'd1);
        chk("lim_ready", 32'(b_in_ready),  32'd0);
        cyc();
        chk("lim_bubble_valid", 32'(b_out_valid), 32'd0);
        cyc(); cyc();
        chk("lim_next_valid", 32'(b_out_valid), 32'd0);
        b_in_last = 1'b1; cyc();
        b_in_valid = 1'b0; b_in_last = 1'b0;
        chk("lim2_valid", 32'(b_out_valid), 32'd1);
        chk("lim2_data",  b_out_data,       32'd3);
        chk("lim2_terms", 32'(b_out_terms), 32'd3);
        cyc();

        // Asynchronous reset mid-pixel
        in_valid = 1'b1; in_data = 32'd50; in_last = 1'b0; cyc(); cyc();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_data",  out_data,       32'd0);
        chk("arst_q",     32'(out_q),     32'd0);
        chk("arst_terms", 32'(out_terms), 32'd0);
        chk("arst_ovf",   32'(ovf),       32'd0);
        chk("arst_b_ovf", 32'(b_ovf),     32'd0);
        cyc();
        rst_n = 1'b1;
        #1;
        in_valid = 1'b1; in_data = 32'd7; in_last = 1'b1; cyc();
        in_valid = 1'b0; in_last = 1'b0;
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_data",  out_data,       32'd7);
        chk("post_rst_terms", 32'(out_terms), 32'd1);
        chk("post_rst_ovf",   32'(ovf),       32'd0);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
